interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the value of trap_pc and epc_o while in reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port timer_irq  input  1  one-cycle timer interrupt pulse.
REQ-005 SHALL have port ext_irq  input  1  external interrupt, level-sensitive.
REQ-006 SHALL have port sw_irq  input  1  software interrupt, level-sensitive.
REQ-007 SHALL have port global_ie  input  1  mstatus.MIE.
REQ-008 SHALL have port irq_en  input  3  mie bits {MEIE, MSIE, MTIE}, bit 2 down to bit 0.
REQ-009 SHALL have port valid_i  input  1  the instruction in the execute stage is valid.
REQ-010 SHALL have port stall_i  input  1  the pipeline is stalled.
REQ-011 SHALL have port pc_i  input  32  the PC of the instruction in the execute stage.
REQ-012 SHALL have port mtvec_i  input  32  trap vector; bits [1:0] set the mode (00 direct, 01 vectored).
REQ-013 SHALL have port mret_i  input  1  an mret retires this cycle.
REQ-014 SHALL have port trap_take  output  1  one-cycle trap-entry strobe.
REQ-015 SHALL have port flush_o  output  1  flushes the fetch and execute stages; equal to trap_take.
REQ-016 SHALL have port trap_pc  output  32  redirect target, valid while trap_take is high.
REQ-017 SHALL have port epc_o  output  32  registered value for mepc.
REQ-018 SHALL have port cause_o  output  32  registered value for mcause.
REQ-019 SHALL have port pending_o  output  3  mip view {MEIP, MSIP, MTIP}.

Function
REQ-020 SHALL set MTIP, a sticky latch, on the cycle after timer_irq is high, and SHALL clear it only on the timer trap_take.
REQ-021 SHALL drive MEIP and MSIP directly from ext_irq and sw_irq, with no latching.
REQ-022 SHALL form the enabled set as pending_o & irq_en, qualified by global_ie.
REQ-023 SHALL select between enabled requests by fixed priority: MEI (code 11) over MSI (code 3) over MTI (code 7).
REQ-024 SHALL implement an FSM with states IDLE, WAIT_BND, TRAP and IN_HANDLER.
REQ-025 SHALL move IDLE->WAIT_BND when the enabled set is non-zero.
REQ-026 SHALL move WAIT_BND->TRAP when valid_i && !stall_i, and WAIT_BND->IDLE if the enabled set falls to zero first.
REQ-027 SHALL in TRAP, for exactly one cycle: assert trap_take and flush_o; latch epc_o=pc_i; latch cause_o={1'b1,27'b0,code}; then move to IN_HANDLER.
REQ-028 SHALL re-evaluate the winning request on the boundary cycle and use that result, not the result from IDLE.
REQ-029 SHALL set trap_pc={mtvec_i[31:2],2'b00} in direct mode and {mtvec_i[31:2],2'b00}+(code<<2) in vectored mode; modes 10 and 11 SHALL behave as direct.
REQ-030 SHALL ignore all requests in IN_HANDLER (nested traps masked), while MTIP still latches; mret_i SHALL return the FSM to IDLE.
REQ-031 SHALL leave MTIP set when a timer_irq pulse coincides with the timer trap_take (set wins).
REQ-032 SHALL ignore mret_i outside IN_HANDLER.
REQ-033 SHALL have a trap latency of 2 cycles from the request appearing in IDLE to trap_take when the pipeline is not stalled.

Reset
REQ-034 SHALL on rst immediately: enter IDLE; clear MTIP; drive trap_take=0 and flush_o=0; set epc_o=RESET_VECTOR and cause_o=0.
REQ-035 SHALL on reset during TRAP or IN_HANDLER abandon the trap with no strobe after reset is released.

Structure
REQ-036 SHALL take the state enum, cause codes (11/3/7) and mtvec mode constants from a shared package irq_pkg.
REQ-037 SHALL place the fixed-priority selection and cause encoding in the combinational sub-module irq_arbiter (input: 3-bit request; outputs: valid and 4-bit code).

Verification
REQ-038 Bench SHALL cover: timer_irq pulse, irq_en=3'b001, global_ie=1, pipeline free, pc_i=32'h40 -> trap_take 2 cycles later, epc_o=32'h40, cause_o=32'h8000_0007, MTIP cleared.
REQ-039 Bench SHALL cover: ext_irq and MTIP together, irq_en=3'b111 -> cause code 11; after mret_i, a second trap with code 7.
REQ-040 Bench SHALL cover: mtvec_i=32'h100 (direct) vs 32'h101 (vectored) with timer trap -> trap_pc 32'h100 vs 32'h11C.
REQ-041 Bench SHALL cover: stall_i high for 5 cycles in WAIT_BND -> no trap_take until the first cycle with stall_i=0 and valid_i=1.
REQ-042 Bench SHALL cover: timer_irq while in IN_HANDLER -> no trap until mret_i, then a trap with code 7.
REQ-043 Bench SHALL cover: rst asserted in TRAP -> trap_take=0 immediately, MTIP=0, FSM in IDLE.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package irq_pkg;

  // Trap-entry sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_BND   = 2'd1,
    ST_TRAP       = 2'd2,
    ST_IN_HANDLER = 2'd3
  } irq_state_e;

  // mcause exception codes for the three machine interrupt sources.
  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  // Bit positions inside the {MEIP, MSIP, MTIP} / {MEIE, MSIE, MTIE} vectors.
  localparam int IRQ_MTI_BIT = 0;
  localparam int IRQ_MSI_BIT = 1;
  localparam int IRQ_MEI_BIT = 2;

  // mtvec[1:0] mode encodings; the reserved encodings fall back to direct.
  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  // Redirect target for a trap with the given cause code.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic [3:0]  code);
    logic [31:0] base;
    logic [31:0] target;
    base = {mtvec[31:2], 2'b00};
    case (mtvec[1:0])
      MTVEC_DIRECT:   target = base;
      MTVEC_VECTORED: target = base + {26'd0, code, 2'b00};
      default:        target = base;
    endcase
    return target;
  endfunction

  // mcause word for an interrupt: interrupt flag set, code in the low bits.
  function automatic logic [31:0] cause_word(input logic [3:0] code);
    return {1'b1, 27'd0, code};
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Fixed-priority selection among enabled interrupt requests: MEI > MSI > MTI.
module irq_arbiter
  import irq_pkg::*;
(
  input  logic [2:0] req_i,
  output logic       valid_o,
  output logic [3:0] code_o
);

  // Priority encode the request vector into a cause code.
  always_comb begin
    valid_o = |req_i;
    code_o  = 4'd0;
    if (req_i[IRQ_MEI_BIT]) begin
      code_o = CAUSE_MEI;
    end else if (req_i[IRQ_MSI_BIT]) begin
      code_o = CAUSE_MSI;
    end else if (req_i[IRQ_MTI_BIT]) begin
      code_o = CAUSE_MTI;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Machine-mode interrupt controller: latches the timer pulse, arbitrates the
// enabled sources, waits for an instruction boundary and issues a one-cycle
// trap-entry strobe with redirect target, mepc and mcause values.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | no enabled request; watching the enabled set
// WAIT_BND     | request seen; waiting for a valid, unstalled instruction
// TRAP         | trap-entry cycle: strobe, flush, capture epc/cause
// IN_HANDLER   | handler running; new requests masked until mret
module interrupt_controller
  import irq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_irq,
  input  logic        ext_irq,
  input  logic        sw_irq,
  input  logic        global_ie,
  input  logic [2:0]  irq_en,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] mtvec_i,
  input  logic        mret_i,
  output logic        trap_take,
  output logic        flush_o,
  output logic [31:0] trap_pc,
  output logic [31:0] epc_o,
  output logic [31:0] cause_o,
  output logic [2:0]  pending_o
);

  irq_state_e  state_q, state_d;
  logic        mtip_q, mtip_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;

  logic [2:0]  enabled;
  logic        arb_valid;
  logic [3:0]  arb_code;
  logic        boundary;
  logic        mtip_clr;

  assign pending_o = {ext_irq, sw_irq, mtip_q};
  assign enabled   = pending_o & irq_en & {3{global_ie}};
  assign boundary  = valid_i & ~stall_i;

  irq_arbiter u_arbiter (
    .req_i   (enabled),
    .valid_o (arb_valid),
    .code_o  (arb_code)
  );

  // Next-state and strobe logic; the winning code is captured on the
  // boundary cycle so a late higher-priority request still wins.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    trap_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_WAIT_BND;
        end
      end
      ST_WAIT_BND: begin
        if (!arb_valid) begin
          state_d = ST_IDLE;
        end else if (boundary) begin
          state_d = ST_TRAP;
          code_d  = arb_code;
        end
      end
      ST_TRAP: begin
        trap_take = 1'b1;
        state_d   = ST_IN_HANDLER;
      end
      ST_IN_HANDLER: begin
        if (mret_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Timer pending latch: a new pulse beats the clear from its own trap.
  always_comb begin
    mtip_clr = trap_take && (code_q == CAUSE_MTI);
    mtip_d   = timer_irq | (mtip_q & ~mtip_clr);
  end

  // mepc/mcause capture on the trap-entry cycle.
  always_comb begin
    epc_d   = epc_q;
    cause_d = cause_q;
    if (trap_take) begin
      epc_d   = pc_i;
      cause_d = cause_word(code_q);
    end
  end

  // State registers; reset drops any in-flight trap without a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mtip_q  <= 1'b0;
      code_q  <= 4'd0;
      epc_q   <= RESET_VECTOR;
      cause_q <= 32'd0;
    end else begin
      state_q <= state_d;
      mtip_q  <= mtip_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  assign flush_o = trap_take;
  assign epc_o   = epc_q;
  assign cause_o = cause_q;
  assign trap_pc = rst ? RESET_VECTOR : trap_target(mtvec_i, code_q);

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: each expected trap is queued when
// its stimulus is driven and compared when trap_take appears.
module tb_interrupt_controller;

  localparam logic [31:0] RV = 32'hDEAD_BE00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        timer_irq = 1'b0;
  logic        ext_irq = 1'b0;
  logic        sw_irq = 1'b0;
  logic        global_ie = 1'b0;
  logic [2:0]  irq_en = 3'b000;
  logic        valid_i = 1'b0;
  logic        stall_i = 1'b0;
  logic [31:0] pc_i = 32'd0;
  logic [31:0] mtvec_i = 32'd0;
  logic        mret_i = 1'b0;
  logic        trap_take;
  logic        flush_o;
  logic [31:0] trap_pc;
  logic [31:0] epc_o;
  logic [31:0] cause_o;
  logic [2:0]  pending_o;

  interrupt_controller #(.RESET_VECTOR(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .timer_irq (timer_irq),
    .ext_irq   (ext_irq),
    .sw_irq    (sw_irq),
    .global_ie (global_ie),
    .irq_en    (irq_en),
    .valid_i   (valid_i),
    .stall_i   (stall_i),
    .pc_i      (pc_i),
    .mtvec_i   (mtvec_i),
    .mret_i    (mret_i),
    .trap_take (trap_take),
    .flush_o   (flush_o),
    .trap_pc   (trap_pc),
    .epc_o     (epc_o),
    .cause_o   (cause_o),
    .pending_o (pending_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] tpc;
    int          at;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  logic ep_pend = 1'b0;

  function automatic logic [31:0] exp_vec(input logic [31:0] mtvec, input int code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01) return base + 32'(code * 4);
    return base;
  endfunction

  task automatic push(input logic [31:0] pc, input int code, input int at);
    exp_t e;
    e.pc    = pc;
    e.cause = 32'h8000_0000 | 32'(code);
    e.tpc   = exp_vec(mtvec_i, code);
    e.at    = at;
    sb_q.push_back(e);
  endtask

  // Trap monitor: pops the scoreboard on every strobe, checks mepc/mcause a cycle later.
  always @(negedge clk) begin
    if (rst) begin
      ep_pend = 1'b0;
    end else begin
      if (ep_pend) begin
        chk("epc", epc_o, cur.pc);
        chk("cause", cause_o, cur.cause);
        ep_pend = 1'b0;
      end
      if (trap_take) begin
        chk("flush", {31'd0, flush_o}, 32'd1);
        if (sb_q.size() == 0) begin
          chk("unexpected_trap", {31'd0, trap_take}, 32'd0);
        end else begin
          cur = sb_q.pop_front();
          chk("trap_pc", trap_pc, cur.tpc);
          if (cur.at >= 0) chk("latency", cyc, cur.at);
          ep_pend = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_trap(input int budget);
    int n;
    n = 0;
    while (!trap_take && n < budget) begin
      tick();
      n++;
    end
    if (!trap_take) chk("trap_timeout", {31'd0, trap_take}, 32'd1);
  endtask

  task automatic do_mret();
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
  endtask

  task automatic timer_pulse();
    timer_irq = 1'b1;
    tick();
    timer_irq = 1'b0;
  endtask

  logic [31:0] mtvec_tab [4] = '{32'h100, 32'h101, 32'h103, 32'h102};

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_trap_take", {31'd0, trap_take}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_epc", epc_o, RV);
    chk("rst_cause", cause_o, 32'd0);
    chk("rst_trap_pc", trap_pc, RV);
    chk("rst_pending", {29'd0, pending_o}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    global_ie = 1'b1;
    valid_i   = 1'b1;
    pc_i      = 32'h40;
    mtvec_i   = 32'h100;
    irq_en    = 3'b001;
    tick();

    // Basic timer trap: latency, epc/cause, MTIP cleared.
    push(32'h40, 7, cyc + 3);
    timer_pulse();
    chk("mtip_set", {29'd0, pending_o}, 32'd1);
    wait_trap(10);
    tick();
    chk("one_shot", {31'd0, trap_take}, 32'd0);
    chk("mtip_clr", {31'd0, pending_o[0]}, 32'd0);
    do_mret();
    repeat (2) tick();

    // External and timer together: MEI first, then MTI after mret.
    irq_en  = 3'b111;
    ext_irq = 1'b1;
    push(32'h40, 11, cyc + 2);
    timer_pulse();
    wait_trap(10);
    tick();
    ext_irq = 1'b0;
    repeat (3) tick();
    chk("mtip_kept", {29'd0, pending_o}, 32'd1);
    push(32'h40, 7, cyc + 3);
    do_mret();
    wait_trap(10);
    tick();
    do_mret();
    repeat (2) tick();

    // Direct, vectored and reserved mtvec modes.
    irq_en = 3'b001;
    for (int i = 0; i < 4; i++) begin
      mtvec_i = mtvec_tab[i];
      push(32'h40, 7, cyc + 3);
      timer_pulse();
      wait_trap(10);
      tick();
      do_mret();
      tick();
    end
    mtvec_i = 32'h100;

    // Stalled boundary: no trap until stall drops and valid is high.
    pc_i    = 32'h200;
    stall_i = 1'b1;
    timer_pulse();
    repeat (6) tick();
    chk("stall_hold", {31'd0, trap_take}, 32'd0);
    stall_i = 1'b0;
    valid_i = 1'b0;
    tick();
    chk("invalid_hold", {31'd0, trap_take}, 32'd0);
    valid_i = 1'b1;
    push(32'h200, 7, cyc + 1);
    wait_trap(10);
    tick();
    do_mret();
    tick();

    // Winner re-evaluated on the boundary cycle: MEI seen in IDLE, MSI wins.
    irq_en  = 3'b111;
    valid_i = 1'b0;
    pc_i    = 32'h300;
    ext_irq = 1'b1;
    repeat (2) tick();
    ext_irq = 1'b0;
    sw_irq  = 1'b1;
    valid_i = 1'b1;
    push(32'h300, 3, cyc + 1);
    wait_trap(10);
    tick();
    sw_irq = 1'b0;
    do_mret();
    tick();

    // Timer pulse coinciding with timer trap, and another inside the handler.
    irq_en = 3'b001;
    pc_i   = 32'h44;
    push(32'h44, 7, cyc + 3);
    timer_pulse();
    wait_trap(10);
    timer_pulse();
    chk("set_wins", {31'd0, pending_o[0]}, 32'd1);
    repeat (3) tick();
    timer_pulse();
    repeat (3) tick();
    chk("nested_masked", {31'd0, trap_take}, 32'd0);
    chk("mtip_in_handler", {31'd0, pending_o[0]}, 32'd1);
    push(32'h44, 7, cyc + 3);
    do_mret();
    wait_trap(10);
    tick();
    chk("mtip_clr2", {31'd0, pending_o[0]}, 32'd0);
    do_mret();
    tick();

    // Global enable masks everything.
    irq_en    = 3'b111;
    global_ie = 1'b0;
    ext_irq   = 1'b1;
    repeat (5) tick();
    chk("gie_mask", {31'd0, trap_take}, 32'd0);
    ext_irq   = 1'b0;
    global_ie = 1'b1;
    tick();

    // Reset during TRAP abandons the trap.
    irq_en = 3'b001;
    timer_pulse();
    wait_trap(10);
    rst = 1'b1;
    #1;
    chk("rst_trap_drop", {31'd0, trap_take}, 32'd0);
    chk("rst_flush_drop", {31'd0, flush_o}, 32'd0);
    chk("rst_mtip", {31'd0, pending_o[0]}, 32'd0);
    chk("rst_epc2", epc_o, RV);
    chk("rst_cause2", cause_o, 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("no_stale_strobe", {31'd0, trap_take}, 32'd0);
    pc_i = 32'h48;
    push(32'h48, 7, cyc + 3);
    timer_pulse();
    wait_trap(10);
    tick();
    do_mret();
    repeat (3) tick();

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
